// File: rtl/operand_fifo32.sv
// Show-ahead operand FIFO (DEPTH x 32b). A pushed word appears on Q one cycle later.
// in_ready and out_valid are derived from registered state only: a full FIFO refuses pushes even when a pop happens the same cycle.
module operand_fifo32 #(
  parameter int DEPTH = 4
) (
  input  logic                     C,
  input  logic                     R,
  input  logic [31:0]              D,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [31:0]              Q,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   storage [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          push;
  logic          pop;

  // DEPTH is a power of two, so the count is full exactly when its top bit is set.
  assign in_ready  = ~count[AW];
  assign out_valid = (count != '0);
  assign Q         = storage[rd_ptr];

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_ff @(posedge C or posedge R) begin
    if (R) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        storage[i] <= 32'h0;
      end
    end else begin
      if (push) begin
        storage[wr_ptr] <= D;
        wr_ptr          <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      // A simultaneous push and pop leaves the count unchanged.
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_fifo32.sv
// Directed bench for operand_fifo32 (DEPTH = 4); inputs change and outputs are sampled on the falling edge of C.
module tb_operand_fifo32;

  logic        C;
  logic        R;
  logic [31:0] D;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] Q;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;

  operand_fifo32 #(.DEPTH(4)) dut (
    .C         (C),
    .R         (R),
    .D         (D),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Q         (Q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  // Apply one cycle of inputs; returns on the next falling edge, after the rising edge has acted.
  task automatic cycle(input logic iv, input logic [31:0] d, input logic ordy);
    in_valid  = iv;
    D         = d;
    out_ready = ordy;
    @(negedge C);
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    R = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    D = 32'h0;
    @(negedge C);
    @(negedge C);
    R = 1'b0;
    checks++; if (count !== 3'd0)     begin failures++; $display("FAIL reset_count got=%0d want=0", count); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (Q !== 32'h0)        begin failures++; $display("FAIL reset_q got=%h want=00000000", Q); end
  endtask

  task automatic test_single_push;
    cycle(1'b1, 32'hDEADBEEF, 1'b0);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_out_valid got=%b want=1", out_valid); end
    checks++; if (Q !== 32'hDEADBEEF) begin failures++; $display("FAIL single_q got=%h want=deadbeef", Q); end
    checks++; if (count !== 3'd1)     begin failures++; $display("FAIL single_count got=%0d want=1", count); end
    cycle(1'b0, 32'h0, 1'b1);
    checks++; if (count !== 3'd0)     begin failures++; $display("FAIL single_pop_count got=%0d want=0", count); end
  endtask

  task automatic test_fill_drain;
    for (int i = 1; i <= 4; i++) cycle(1'b1, 32'(i), 1'b0);
    checks++; if (count !== 3'd4)    begin failures++; $display("FAIL fill_count got=%0d want=4", count); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_in_ready got=%b want=0", in_ready); end
    cycle(1'b1, 32'd5, 1'b0);
    checks++; if (count !== 3'd4)    begin failures++; $display("FAIL fill_overflow_count got=%0d want=4", count); end
    for (int i = 1; i <= 4; i++) begin
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL drain_out_valid_%0d got=%b want=1", i, out_valid); end
      checks++; if (Q !== 32'(i))       begin failures++; $display("FAIL drain_q_%0d got=%h want=%h", i, Q, 32'(i)); end
      cycle(1'b0, 32'h0, 1'b1);
    end
    checks++; if (count !== 3'd0)     begin failures++; $display("FAIL drain_count got=%0d want=0", count); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drain_out_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_empty_pop;
    cycle(1'b0, 32'h0, 1'b1);
    checks++; if (count !== 3'd0)     begin failures++; $display("FAIL empty_pop_count got=%0d want=0", count); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL empty_pop_out_valid got=%b want=0", out_valid); end
    cycle(1'b1, 32'hCAFE0001, 1'b0);
    checks++; if (Q !== 32'hCAFE0001) begin failures++; $display("FAIL empty_pop_next_q got=%h want=cafe0001", Q); end
    cycle(1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_simultaneous;
    cycle(1'b1, 32'h0000000A, 1'b0);
    cycle(1'b1, 32'h0000000B, 1'b0);
    checks++; if (count !== 3'd2)     begin failures++; $display("FAIL simul_pre_count got=%0d want=2", count); end
    checks++; if (Q !== 32'h0000000A) begin failures++; $display("FAIL simul_pre_q got=%h want=0000000a", Q); end
    cycle(1'b1, 32'h0000000C, 1'b1);
    checks++; if (count !== 3'd2)     begin failures++; $display("FAIL simul_count got=%0d want=2", count); end
    checks++; if (Q !== 32'h0000000B) begin failures++; $display("FAIL simul_q got=%h want=0000000b", Q); end
    cycle(1'b0, 32'h0, 1'b1);
    checks++; if (Q !== 32'h0000000C) begin failures++; $display("FAIL simul_second_q got=%h want=0000000c", Q); end
    checks++; if (count !== 3'd1)     begin failures++; $display("FAIL simul_second_count got=%0d want=1", count); end
    cycle(1'b0, 32'h0, 1'b1);
    checks++; if (count !== 3'd0)     begin failures++; $display("FAIL simul_end_count got=%0d want=0", count); end
  endtask

  task automatic test_full_push_pop;
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h10 + 32'(i), 1'b0);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%b want=0", in_ready); end
    cycle(1'b1, 32'h00000099, 1'b1);
    checks++; if (count !== 3'd3)     begin failures++; $display("FAIL full_pp_count got=%0d want=3", count); end
    checks++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL full_pp_in_ready got=%b want=1", in_ready); end
    checks++; if (Q !== 32'h00000011) begin failures++; $display("FAIL full_pp_q got=%h want=00000011", Q); end
    for (int i = 1; i < 4; i++) begin
      checks++; if (Q !== 32'h10 + 32'(i)) begin failures++; $display("FAIL full_drain_q_%0d got=%h want=%h", i, Q, 32'h10 + 32'(i)); end
      cycle(1'b0, 32'h0, 1'b1);
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL full_drain_out_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_back_to_back;
    cycle(1'b1, 32'd0, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      checks++; if (Q !== 32'(i - 1)) begin failures++; $display("FAIL wrap_q_%0d got=%h want=%h", i - 1, Q, 32'(i - 1)); end
      checks++; if (count !== 3'd1)   begin failures++; $display("FAIL wrap_count_%0d got=%0d want=1", i - 1, count); end
      cycle(1'b1, 32'(i), 1'b1);
    end
    checks++; if (Q !== 32'd9) begin failures++; $display("FAIL wrap_q_9 got=%h want=00000009", Q); end
    cycle(1'b0, 32'h0, 1'b1);
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL wrap_end_count got=%0d want=0", count); end
  endtask

  task automatic test_mid_reset;
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h21 + 32'(i), 1'b0);
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL midrst_pre_count got=%0d want=3", count); end
    #2 R = 1'b1;
    #2;
    checks++; if (count !== 3'd0)     begin failures++; $display("FAIL midrst_async_count got=%0d want=0", count); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_async_out_valid got=%b want=0", out_valid); end
    checks++; if (Q !== 32'h0)        begin failures++; $display("FAIL midrst_async_q got=%h want=00000000", Q); end
    checks++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL midrst_async_in_ready got=%b want=1", in_ready); end
    cycle(1'b1, 32'h00000077, 1'b1);
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL midrst_held_count got=%0d want=0", count); end
    R = 1'b0;
    cycle(1'b1, 32'h12345678, 1'b0);
    checks++; if (Q !== 32'h12345678) begin failures++; $display("FAIL midrst_post_q got=%h want=12345678", Q); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL midrst_post_out_valid got=%b want=1", out_valid); end
    checks++; if (count !== 3'd1)     begin failures++; $display("FAIL midrst_post_count got=%0d want=1", count); end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_fill_drain();
    test_empty_pop();
    test_simultaneous();
    test_full_push_pop();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/operand_fifo32.md
OPERAND_FIFO32 -- requirements
Module: operand_fifo32

Interface
REQ-001 SHALL have parameter: DEPTH, default 4, number of 32-bit entries (power of 2, >= 2).
REQ-002 SHALL have port: C  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port: R  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: D  input  32  write data (operand destined for the 32-bit PE register bank).
REQ-005 SHALL have port: in_valid  input  1  producer presents D this cycle.
REQ-006 SHALL have port: in_ready  output  1  FIFO can accept a word this cycle.
REQ-007 SHALL have port: Q  output  32  head-of-queue data, feeds the downstream 32-bit register D input.
REQ-008 SHALL have port: out_valid  output  1  Q holds a valid head entry.
REQ-009 SHALL have port: out_ready  input  1  consumer takes Q this cycle.
REQ-010 SHALL have port: count  output  clog2(DEPTH)+1  number of stored entries.

Function
REQ-011 SHALL perform push when in_valid && in_ready at a rising edge of C: store D at write pointer, advance write pointer.
REQ-012 SHALL perform pop when out_valid && out_ready at a rising edge of C: advance read pointer.
REQ-013 SHALL drive in_ready = (count < DEPTH), a function of registered state only; no combinational path from out_ready.
REQ-014 SHALL drive out_valid = (count != 0), registered-state only; no combinational path from in_valid.
REQ-015 SHALL drive Q = storage[read pointer] (show-ahead); Q meaningful only while out_valid = 1.
REQ-016 SHALL give push-to-out_valid latency of exactly 1 cycle when empty (word pushed at edge N visible on Q after edge N).
REQ-017 SHALL wrap read and write pointers modulo DEPTH with no skipped or duplicated entry.
REQ-018 SHALL update count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-019 SHALL, when full (count = DEPTH), hold in_ready = 0 and ignore in_valid even if out_ready = 1 that cycle; pop proceeds, in_ready rises next cycle.
REQ-020 SHALL, when empty, ignore out_ready; count never underflows, pointers unchanged.
REQ-021 SHALL, with count between 1 and DEPTH-1, accept simultaneous push and pop in the same edge; popped word is old head, pushed word appended at tail.
REQ-022 SHALL preserve strict FIFO order: words leave in the exact order accepted.
REQ-023 SHALL hold Q, storage and pointers stable on cycles with neither push nor pop.

Reset
REQ-024 SHALL on R = 1, immediately (without waiting for C) clear read pointer, write pointer and count to 0 and all storage entries to 32'h0.
REQ-025 SHALL present after reset: Q = 32'h0, out_valid = 0, in_ready = 1, count = 0.
REQ-026 SHALL, if R asserts mid-operation (including a coincident push/pop edge), discard all stored entries; no push or pop takes effect while R = 1.
REQ-027 SHALL resume normal operation on the first rising edge of C after R deasserts.

Verification
REQ-028 SHALL cover: reset, then push 32'hDEADBEEF with out_ready = 0 -> next cycle out_valid = 1, Q = 32'hDEADBEEF, count = 1.
REQ-029 SHALL cover: push 1,2,3,4 (DEPTH = 4) with out_ready = 0 -> count = 4, in_ready = 0; fifth push of 5 ignored; then drain -> Q sequence 1,2,3,4, count = 0, out_valid = 0.
REQ-030 SHALL cover: count = 2 (A,B), simultaneous push C and pop -> count stays 2, Q = B; next pops yield B then C.
REQ-031 SHALL cover: full, in_valid = 1 and out_ready = 1 same edge -> only pop occurs, count = 3, in_ready = 1 next cycle, rejected word absent from output.
REQ-032 SHALL cover: 10 push/pop pairs with values 0..9 through DEPTH = 4 -> pointer wrap, output order 0..9 exact, no loss.
REQ-033 SHALL cover: count = 3, assert R between clock edges -> count = 0, out_valid = 0, Q = 32'h0 before next edge; post-reset push 32'h12345678 -> Q = 32'h12345678 next cycle.
